// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then holds the result until taken.
//
// state | meaning
// IDLE  | waiting for an input state, in_ready high
// BUSY  | transforming columns of the working register
// DONE  | result valid, waiting for out_ready
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e       state_q;
  logic [1:0]   col_q;
  logic [127:0] work_q;
  logic [127:0] work_d;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic [1:0]   idx;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m09[4];
    logic [7:0] m0b[4];
    logic [7:0] m0d[4];
    logic [7:0] m0e[4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]   = c[31-8*r -: 8];
      x2     = xtime(a[r]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m09[r] = x8 ^ a[r];
      m0b[r] = x8 ^ x2 ^ a[r];
      m0d[r] = x8 ^ x4 ^ a[r];
      m0e[r] = x8 ^ x4 ^ x2;
    end
    return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
            m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
            m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
            m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
  endfunction

  // Column c lives at bits [(3-c)*32 +: 32]; one transform per column slot.
  always_comb begin
    work_d = work_q;
    idx    = '0;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      idx = col_q + 2'(g);
      work_d[(3 - idx) * 32 +: 32] = inv_col(work_q[(3 - idx) * 32 +: 32]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            work_q     <= in_state;
            col_q      <= '0;
            state_q    <= S_BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_BUSY: begin
          work_q <= work_d;
          if (col_q == COL_LAST) begin
            col_q       <= '0;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            col_q <= col_q + COL_STEP;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          col_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: instances with 1, 2 and 4 columns
// per cycle, checked against a matrix-multiply GF(2^8) reference and a cycle model.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         iv   [3];
  logic         irdy [3];
  logic [127:0] ist  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ost  [3];
  logic         bsy  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[g]),
      .in_ready (irdy[g]),
      .in_state (ist[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_state(ost[g]),
      .busy     (bsy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]   idx;
    logic [127:0] st;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errs   = 0;

  // Reference: generic shift-and-add GF(2^8) multiply, circulant matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0]   base[4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(base[(j - row + 4) % 4], s[127 - 8*(j + 4*c) -: 8]);
        r[127 - 8*(row + 4*c) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input int k, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[cols=%0d] at %0t: got %h expected %h", name, 1 << k, $time, act, exp);
    end
  endtask

  // Cycle model: 0 idle, 1 busy, 2 done.
  int           ph   [3] = '{0, 0, 0};
  int           rem  [3];
  bit           zero [3] = '{1, 1, 1};
  bit           held [3] = '{0, 0, 0};
  logic [127:0] hold_v[3];
  exp_t         e;

  always @(negedge clk) begin
    if (rst) sb_q.delete();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        ph[k] = 0; zero[k] = 1; held[k] = 0;
      end
      chk("in_ready",  k, 128'(irdy[k]), 128'(ph[k] == 0));
      chk("out_valid", k, 128'(ov[k]),   128'(ph[k] == 2));
      chk("busy",      k, 128'(bsy[k]),  128'(ph[k] != 0));
      if (zero[k]) chk("out_state_zero", k, ost[k], 128'h0);
      if (!rst) begin
        if (ph[k] == 2) begin
          if (held[k]) chk("out_state_stable", k, ost[k], hold_v[k]);
          held[k] = 1; hold_v[k] = ost[k];
          if (ordy[k]) begin
            if (sb_q.size() == 0) begin
              chk("unexpected_output", k, 128'(1), 128'(0));
            end else begin
              e = sb_q.pop_front();
              chk("result_instance", k, 128'(e.idx), 128'(k));
              chk("out_state", k, ost[k], e.st);
            end
            ph[k] = 0; held[k] = 0;
          end
        end else if (ph[k] == 1) begin
          if (rem[k] == 1) ph[k] = 2;
          else rem[k]--;
        end else if (iv[k]) begin
          ph[k] = 1; rem[k] = 4 >> k; zero[k] = 0;
        end
      end
    end
  end

  int rdy_mode;
  bit rdy_force[3];

  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++)
        ordy[k] = (rdy_mode == 0) ? 1'b1 :
                  (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : rdy_force[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [127:0] s, input logic [127:0] expv,
                      input bit hold);
    int n = 0;
    iv[k] = 1'b1;
    ist[k] = s;
    @(negedge clk);
    while (!irdy[k]) begin
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout[cols=%0d] got no in_ready expected in_ready", 1 << k);
        $fatal(1);
      end
      @(negedge clk);
    end
    sb_q.push_back('{idx: 2'(k), st: expv});
    tick();
    if (!hold) iv[k] = 1'b0;
    ist[k] = rand128();
  endtask

  task automatic wait_ov(input int k);
    int n = 0;
    @(negedge clk);
    while (!ov[k]) begin
      n++;
      if (n > 200) begin
        $display("FAIL out_valid_timeout[cols=%0d] got 0 expected 1", 1 << k);
        $fatal(1);
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb_q.size() != 0) begin
      n++;
      if (n > 500) begin
        $display("FAIL drain_timeout pending %0d expected 0", sb_q.size());
        $fatal(1);
      end
      tick();
    end
    tick();
  endtask

  logic [127:0] s;

  initial begin
    rst = 1'b1;
    rdy_mode = 0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ist[k] = '0; ordy[k] = 1'b1; rdy_force[k] = 1'b1;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of a transform: nothing may come out.
    s = rand128();
    send(0, s, mix(s, 1), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Known columns, in_valid held high and in_state changed while busy.
    rdy_mode = 2;
    rdy_force[0] = 1'b0;
    send(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
            128'hdb135345_f20a225c_01010101_c6c6c6c6, 1);
    wait_ov(0);
    tick();
    iv[0] = 1'b0;
    rdy_force[0] = 1'b1;
    wait_empty();

    rdy_mode = 0;
    send(1, 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff,
            128'h2d26314c_d4d4d4d5_00000000_ffffffff, 0);
    wait_empty();

    // Backpressure on the single-cycle instance with input noise while DONE.
    rdy_mode = 2;
    rdy_force[2] = 1'b0;
    s = rand128();
    send(2, s, mix(s, 1), 0);
    wait_ov(2);
    for (int i = 0; i < 10; i++) begin
      tick();
      iv[2] = 1'($urandom_range(0, 1));
      ist[2] = rand128();
    end
    iv[2] = 1'b0;
    rdy_force[2] = 1'b1;
    wait_empty();

    rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 100; i++) begin
        s = rand128();
        send(k, s, mix(s, 1), 0);
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_empty();
      for (int i = 0; i < 50; i++) begin
        s = rand128();
        send(k, mix(s, 0), s, 0);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_empty();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
